// File: rtl/enum_type.sv
// Shared game enumerations plus the ASCII helpers used by the UART reporter.
// cmd_to_key maps a control command onto its lowercase keyboard letter.
package enum_type;

  typedef enum logic [3:0] {
    NONE,
    LEFT,
    RIGHT,
    DOWN,
    DROP,
    HOLD,
    ROTATE,
    ROTATE_REV,
    BAR,
    PAUSE
  } state_type;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;

  // A zero result marks a code that has no echo key.
  function automatic logic [7:0] cmd_to_key(input state_type c);
    case (c)
      LEFT:       cmd_to_key = 8'h61;  // 'a'
      RIGHT:      cmd_to_key = 8'h64;  // 'd'
      DOWN:       cmd_to_key = 8'h73;  // 's'
      DROP:       cmd_to_key = 8'h77;  // 'w'
      HOLD:       cmd_to_key = 8'h63;  // 'c'
      ROTATE:     cmd_to_key = 8'h78;  // 'x'
      ROTATE_REV: cmd_to_key = 8'h7A;  // 'z'
      BAR:        cmd_to_key = 8'h62;  // 'b'
      default:    cmd_to_key = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/game_reporter_pkg.sv
// State encodings for the game_reporter formatter and transmit FSMs.
package game_reporter_pkg;

  typedef enum logic [2:0] {
    F_IDLE,
    F_START,
    F_OVER,
    F_DIGIT,
    F_CR,
    F_LF
  } fmt_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_PULSE,
    T_BUSY,
    T_DONE
  } tx_state_t;

  localparam int NUM_DIGITS = 5;

endpackage

// File: rtl/game_reporter_if.sv
// Transmit handshake between game_reporter (master) and the uart core (slave).
interface game_reporter_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting;

  modport master (output transmit, output tx_byte, input is_transmitting);
  modport slave  (input transmit, input tx_byte, output is_transmitting);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered read data (no fall-through).
// DEPTH must be a power of two; push while full is accepted only alongside a pop.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              do_push, do_pop;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // When full, the slot being read is the one being overwritten, which is safe
  // because the read sees the old contents.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/game_reporter.sv
// Formats game start/over events (and, with GAME_REPORTER_CMD_ECHO_EN, command
// echoes) as ASCII and feeds them one byte at a time to the uart transmitter.
module game_reporter
  import enum_type::*;
  import game_reporter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SCORE_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 over_i,
  input  logic [SCORE_W-1:0]   score,
  input  logic                 cmd_valid,
  input  state_type            cmd,
  game_reporter_if.master      uart,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] POW10 [NUM_DIGITS] = '{32'd10000, 32'd1000, 32'd100, 32'd10, 32'd1};

  logic               start_prev_q, over_prev_q;
  logic               pend_start_q, pend_start_d;
  logic               pend_over_q, pend_over_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_rise, over_rise;

  fmt_state_t         fmt_state_q, fmt_state_d;
  logic [31:0]        work_q, work_d;
  logic [2:0]         digit_idx_q, digit_idx_d;
  logic [3:0]         digit_cnt_q, digit_cnt_d;
  logic               clr_start, clr_over, clr_echo;

  tx_state_t          tx_state_q, tx_state_d;
  logic               transmit;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_push_data, fifo_rd_data;
  logic [CNT_W-1:0]   fifo_count;

  logic               echo_pending;
  logic [7:0]         echo_key;

  assign start_rise = start_i && !start_prev_q;
  assign over_rise  = over_i && !over_prev_q;

  // A new edge always wins over a same-cycle clear, so it is never lost.
  always_comb begin
    pend_start_d = (pend_start_q && !clr_start) || start_rise;
    pend_over_d  = (pend_over_q && !clr_over) || over_rise;
    score_d      = score_q;
    if (over_rise && (!pend_over_q || clr_over)) score_d = score;
  end

`ifdef GAME_REPORTER_CMD_ECHO_EN
  logic       echo_full_q, echo_full_d;
  logic [7:0] echo_key_q, echo_key_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] cmd_key;

  assign cmd_key = cmd_to_key(cmd);

  always_comb begin
    echo_full_d = echo_full_q && !clr_echo;
    echo_key_d  = echo_key_q;
    drop_cnt_d  = drop_cnt_q;
    if (cmd_valid && (cmd_key != 8'h00)) begin
      if (echo_full_q) begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        echo_full_d = 1'b1;
        echo_key_d  = cmd_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      echo_full_q <= 1'b0;
      echo_key_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      echo_full_q <= echo_full_d;
      echo_key_q  <= echo_key_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign echo_pending = echo_full_q;
  assign echo_key     = echo_key_q;
  assign drop_cnt     = drop_cnt_q;
`else
  logic unused_cmd;
  assign unused_cmd   = ^{cmd_valid, cmd, clr_echo};
  assign echo_pending = 1'b0;
  assign echo_key     = 8'h00;
  assign drop_cnt     = 8'h00;
`endif

  // Formatter: each byte-producing state waits in place until the FIFO has room.
  always_comb begin
    fmt_state_d    = fmt_state_q;
    work_d         = work_q;
    digit_idx_d    = digit_idx_q;
    digit_cnt_d    = digit_cnt_q;
    fifo_push      = 1'b0;
    fifo_push_data = 8'h00;
    clr_start      = 1'b0;
    clr_over       = 1'b0;
    clr_echo       = 1'b0;
    case (fmt_state_q)
      F_IDLE: begin
        if (pend_over_q) begin
          fmt_state_d = F_OVER;
        end else if (pend_start_q) begin
          fmt_state_d = F_START;
        end else if (echo_pending && !fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = echo_key;
          clr_echo       = 1'b1;
        end
      end
      F_START: begin
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = CH_S;
          clr_start      = 1'b1;
          fmt_state_d    = F_CR;
        end
      end
      F_OVER: begin
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = CH_O;
          clr_over       = 1'b1;
          work_d         = 32'(score_q);
          digit_idx_d    = '0;
          digit_cnt_d    = '0;
          fmt_state_d    = F_DIGIT;
        end
      end
      F_DIGIT: begin
        // Repeated subtraction: one step per cycle, then emit the digit.
        if (work_q >= POW10[digit_idx_q]) begin
          work_d      = work_q - POW10[digit_idx_q];
          digit_cnt_d = digit_cnt_q + 4'd1;
        end else if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = CH_0 + {4'b0000, digit_cnt_q};
          digit_cnt_d    = '0;
          if (digit_idx_q == 3'(NUM_DIGITS - 1)) fmt_state_d = F_CR;
          else digit_idx_d = digit_idx_q + 3'd1;
        end
      end
      F_CR: begin
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = CH_CR;
          fmt_state_d    = F_LF;
        end
      end
      F_LF: begin
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = CH_LF;
          fmt_state_d    = F_IDLE;
        end
      end
      default: fmt_state_d = F_IDLE;
    endcase
  end

  // Transmit: pop into the FIFO read register, pulse once, then follow the uart busy flag.
  always_comb begin
    tx_state_d = tx_state_q;
    fifo_pop   = 1'b0;
    transmit   = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!fifo_empty && !uart.is_transmitting) begin
          fifo_pop   = 1'b1;
          tx_state_d = T_PULSE;
        end
      end
      T_PULSE: begin
        transmit   = 1'b1;
        tx_state_d = T_BUSY;
      end
      T_BUSY: if (uart.is_transmitting) tx_state_d = T_DONE;
      T_DONE: if (!uart.is_transmitting) tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_prev_q <= start_i;
      over_prev_q  <= over_i;
      pend_start_q <= 1'b0;
      pend_over_q  <= 1'b0;
      score_q      <= '0;
      fmt_state_q  <= F_IDLE;
      work_q       <= '0;
      digit_idx_q  <= '0;
      digit_cnt_q  <= '0;
      tx_state_q   <= T_IDLE;
    end else begin
      start_prev_q <= start_i;
      over_prev_q  <= over_i;
      pend_start_q <= pend_start_d;
      pend_over_q  <= pend_over_d;
      score_q      <= score_d;
      fmt_state_q  <= fmt_state_d;
      work_q       <= work_d;
      digit_idx_q  <= digit_idx_d;
      digit_cnt_q  <= digit_cnt_d;
      tx_state_q   <= tx_state_d;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  logic unused_count;
  assign unused_count = ^fifo_count;

  assign uart.transmit = transmit;
  assign uart.tx_byte  = fifo_rd_data;

  assign busy = pend_start_q || pend_over_q || echo_pending ||
                (fmt_state_q != F_IDLE) || !fifo_empty || (tx_state_q != T_IDLE);

endmodule

// File: doc/game_reporter.md
Name: game_reporter

Overview:
- UART transmit-side companion to the game's command receiver. Turns game events into short ASCII messages and drives the uart core's transmit/tx_byte handshake.
- Events reported: game start, game over with final score, and optionally an echo of each accepted control command.
- Sits beside the controller. Takes start/over/score from the game core and owns the uart transmit and tx_byte inputs.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 8.
- SCORE_W, 16, score width; decimal output is always 5 digits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start_i  in  1  game running level; a rising edge means a start event
- over_i  in  1  game over level; a rising edge means an over event
- score  in  SCORE_W  current score, sampled on the over_i rising edge
- cmd_valid  in  1  one-cycle strobe: cmd is an accepted command
- cmd  in  state_type  command code (LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR)
- is_transmitting  in  1  uart busy flag
- transmit  out  1  one-cycle request to the uart
- tx_byte  out  8  byte to send; stable while transmit is high
- busy  out  1  high when any pending event exists, formatter is not idle, FIFO is non-empty, or tx is not idle
- drop_cnt  out  8  saturating count of dropped command echoes

Behaviour:
- Reset (reset_n low at a clock edge): all outputs 0; FIFO empty; pending flags clear; edge detectors load the current input levels, so no spurious edge after reset. Reset mid-message discards the message.
- Edge detect: registered previous levels. A rising edge sets pend_start or pend_over. On the over edge, score latches into score_q.
  - An edge that arrives while its flag is already set merges: no duplicate message, and score_q keeps the first capture.
- Formatter FSM, states F_IDLE, F_START, F_OVER, F_DIGIT, F_CR, F_LF:
  - Priority from F_IDLE: pend_over > pend_start > echo latch.
  - Start message: "S\r\n".
  - Over message: "O", then 5 digits, most significant first, zero-padded, then "\r\n". Example: score 1234 → "O01234\r\n".
  - Digit k: subtract 10^k from a working register once per cycle while remainder ≥ 10^k, then push '0'+count. At most 10 cycles per digit. The constant table holds 10000, 1000, 100, 10, 1.
  - A pending flag clears when the first byte of its message is pushed.
  - Each state pushes one byte only when the FIFO is not full. Otherwise it stalls in place and loses nothing.
- Transmit FSM, states T_IDLE, T_PULSE, T_BUSY, T_DONE:
  - T_IDLE → T_PULSE when the FIFO is non-empty and is_transmitting is low. Pop the head into the tx_byte register.
  - T_PULSE: transmit=1 for exactly one cycle, then go to T_BUSY.
  - T_BUSY: wait for is_transmitting=1, then go to T_DONE.
  - T_DONE: wait for is_transmitting=0, then go to T_IDLE.
  - tx_byte holds its value from T_PULSE until the next pop.
  - Back-to-back bytes: the next transmit pulse comes no earlier than 1 cycle after is_transmitting falls.
- FIFO: simultaneous push and pop are allowed when full or empty. Pop is from the registered head; no first-word fall-through is required.
- Latency from an idle system: the first byte is in the FIFO 2 cycles after the input edge, and transmit pulses 2 cycles after that.

Optional Feature:
- Macro: GAME_REPORTER_CMD_ECHO_EN.
- Enabled:
  - cmd_valid loads a one-entry echo latch with a lowercase key: LEFT 'a', RIGHT 'd', DOWN 's', DROP 'w', HOLD 'c', ROTATE 'x', ROTATE_REV 'z', BAR 'b'.
  - Other codes are ignored.
  - If the latch is full, the new command is dropped and drop_cnt increments, saturating at 255.
  - The echo is pushed as a single byte, with no CR/LF.
- Disabled: cmd and cmd_valid are unused, no echo logic exists, and drop_cnt is tied to 0.

Decomposition:
- Shared package: add ASCII constants (CH_S, CH_O, CH_CR, CH_LF, CH_0) and a function cmd_to_key(state_type) → byte, placed in enum_type next to state_type.
- The decimal table is a localparam array in the module.
- One sub-module: byte_fifo (DEPTH, 8-bit; push/pop/full/empty/count). It is reusable for the receive side.

Test Plan:
- Reset, then start_i 0→1 with the uart model idle → bytes 0x53 0x0D 0x0A, exactly one transmit pulse each; busy returns to 0.
- score=1234, over_i rising → 0x4F 0x30 0x31 0x32 0x33 0x34 0x0D 0x0A. Repeat with score=0 → "O00000\r\n" and score=65535 → "O65535\r\n".
- start_i and over_i rise in the same cycle → complete over message, then "S\r\n"; the two messages never interleave.
- Hold is_transmitting=1 for 10k cycles while 3 over events and 2 start events fire → FIFO fills and the formatter stalls; after release, every byte arrives in order and merged edges produce exactly one message per flag.
- Echo enabled: cmd_valid with LEFT, then ROTATE while the latch is full → 'a' sent, drop_cnt=1. Echo disabled → no bytes, drop_cnt=0.
- Assert reset_n low mid-over-message (after "O01") → transmit=0 next cycle, FIFO empty, and no further bytes after release.
